// File: rtl/freq_gate_ctrl.sv
// Gate-timing controller for the frequency meter: drives the BCD event counter's
// write-enable/clear, latches its digits after each gate and auto-ranges by decade.
module freq_gate_ctrl #(
    parameter int unsigned CLK_HZ     = 1000,
    parameter int unsigned CLR_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] th_d,
    input  logic [3:0] hundred_d,
    input  logic [3:0] ten_d,
    input  logic [3:0] one_d,
    output logic       w_enable,
    output logic       clear,
    output logic [3:0] disp_th,
    output logic [3:0] disp_hu,
    output logic [3:0] disp_te,
    output logic [3:0] disp_on,
    output logic [1:0] range,
    output logic       ovf,
    output logic       valid,
    output logic       latch_pulse
);

    localparam int unsigned CNT_W = $clog2(CLK_HZ + 1);

    // Phase timers count down from length-1 to zero.
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] G0_LOAD     = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] G1_LOAD     = CNT_W'(CLK_HZ / 10 - 1);
    localparam logic [CNT_W-1:0] G2_LOAD     = CNT_W'(CLK_HZ / 100 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LATCH  = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] gate_load_f(input logic [1:0] rng);
        logic [CNT_W-1:0] len;
        case (rng)
            2'd0:    len = G0_LOAD;
            2'd1:    len = G1_LOAD;
            default: len = G2_LOAD;
        endcase
        return len;
    endfunction

    // A thousands digit past 9 means the count no longer fits four digits.
    function automatic logic over_range_f(input logic [3:0] th);
        return (th >= 4'hA);
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [3:0]       samp_th_r;
    logic [3:0]       samp_hu_r;
    logic [3:0]       samp_te_r;
    logic [3:0]       samp_on_r;
    logic [1:0]       range_r;
    logic [1:0]       range_next_s;
    logic             pulse_s;
    logic             over_s;
    logic             w_enable_r;
    logic             clear_r;
    logic [3:0]       disp_th_r;
    logic [3:0]       disp_hu_r;
    logic [3:0]       disp_te_r;
    logic [3:0]       disp_on_r;
    logic             ovf_r;
    logic             valid_r;
    logic             latch_pulse_r;

    assign over_s = over_range_f(samp_th_r);

    // Next-state and phase-timer reload logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    next_state_s = ST_CLEAR;
                    cnt_next_s   = CLR_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = ST_GATE;
                    cnt_next_s   = gate_load_f(range_r);
                end else begin
                    next_state_s = ST_CLEAR;
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_GATE: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = ST_SETTLE;
                    cnt_next_s   = SETTLE_LOAD;
                end else begin
                    next_state_s = ST_GATE;
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = ST_LATCH;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    next_state_s = ST_SETTLE;
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ST_LATCH: begin
                if (run) begin
                    next_state_s = ST_CLEAR;
                    cnt_next_s   = CLR_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Result evaluation in LATCH: an over-range below the top decade retries one range up.
    always_comb begin
        range_next_s = range_r;
        pulse_s      = 1'b0;
        if (state_r == ST_LATCH) begin
            if (over_s) begin
                if (range_r < 2'd2) begin
                    range_next_s = range_r + 2'd1;
                    pulse_s      = 1'b0;
                end else begin
                    range_next_s = range_r;
                    pulse_s      = 1'b1;
                end
            end else begin
                pulse_s = 1'b1;
                if ((samp_th_r == 4'd0) && (range_r != 2'd0)) begin
                    range_next_s = range_r - 2'd1;
                end else begin
                    range_next_s = range_r;
                end
            end
        end else begin
            range_next_s = range_r;
            pulse_s      = 1'b0;
        end
    end

    // State, timers, digit sampling and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            samp_th_r     <= 4'd0;
            samp_hu_r     <= 4'd0;
            samp_te_r     <= 4'd0;
            samp_on_r     <= 4'd0;
            range_r       <= 2'd0;
            w_enable_r    <= 1'b0;
            clear_r       <= 1'b0;
            disp_th_r     <= 4'd0;
            disp_hu_r     <= 4'd0;
            disp_te_r     <= 4'd0;
            disp_on_r     <= 4'd0;
            ovf_r         <= 1'b0;
            valid_r       <= 1'b0;
            latch_pulse_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            cnt_r         <= cnt_next_s;
            range_r       <= range_next_s;
            w_enable_r    <= (next_state_s == ST_CLEAR) || (next_state_s == ST_GATE);
            clear_r       <= (next_state_s == ST_CLEAR);
            latch_pulse_r <= pulse_s;
            if ((state_r == ST_SETTLE) && (cnt_r == CNT_ZERO)) begin
                samp_th_r <= th_d;
                samp_hu_r <= hundred_d;
                samp_te_r <= ten_d;
                samp_on_r <= one_d;
            end
            if (pulse_s) begin
                valid_r <= 1'b1;
                ovf_r   <= over_s;
                if (over_s) begin
                    disp_th_r <= 4'd9;
                    disp_hu_r <= 4'd9;
                    disp_te_r <= 4'd9;
                    disp_on_r <= 4'd9;
                end else begin
                    disp_th_r <= samp_th_r;
                    disp_hu_r <= samp_hu_r;
                    disp_te_r <= samp_te_r;
                    disp_on_r <= samp_on_r;
                end
            end
        end
    end

    assign w_enable    = w_enable_r;
    assign clear       = clear_r;
    assign disp_th     = disp_th_r;
    assign disp_hu     = disp_hu_r;
    assign disp_te     = disp_te_r;
    assign disp_on     = disp_on_r;
    assign range       = range_r;
    assign ovf         = ovf_r;
    assign valid       = valid_r;
    assign latch_pulse = latch_pulse_r;

endmodule
